// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART tx core among N_REQ byte producers, with a write watchdog.
// Ports: clk, reset (async, active-high); req_valid/req_data/req_last in, req_ready out (one-hot accept);
// tx_data/tx_wr out to the core's data_in/data_in_wr, tx_busy in from busy_tx; grant out (owner of the byte
// in flight); err_timeout out (one-cycle watchdog pulse). Define UART_ARB_LOCK_EN to hold a requester until req_last.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_wr,
  input  logic               tx_busy,
  output logic [N_REQ-1:0]   grant,
  output logic               err_timeout
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q;
  logic [PW-1:0] ptr_q, ptr_d, sel, nxt;
  logic [7:0] data_q, cnt_q;
  logic [N_REQ-1:0] grant_q, elig;
  logic wr_q, err_q, found, go, tmo, hold;
  always_comb begin
    logic [PW-1:0] idx;
    found = 1'b0;
    sel = '0;
    idx = '0;
    // scan from the far end back toward ptr so the closest eligible requester wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % N_REQ);
      if (elig[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  assign nxt = PW'((int'(sel) + 1) % N_REQ);
  // tx_busy must be low even in ARB: a late busy after a timeout blocks the next write
  assign go = state_q == ARB && found && !tx_busy;
  assign tmo = !tx_busy && cnt_q == 8'(TIMEOUT - 1);
  assign req_ready = go ? N_REQ'(1) << sel : '0;
`ifdef UART_ARB_LOCK_EN
  logic lock_q;
  assign elig = lock_q ? req_valid & grant_q : req_valid;
  assign ptr_d = req_last[sel] ? nxt : ptr_q;
  assign hold = lock_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) lock_q <= 1'b0;
    else if (go) lock_q <= !req_last[sel];
    else if (state_q == WAIT_BUSY && tmo) lock_q <= 1'b0;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig = req_valid;
  assign ptr_d = nxt;
  assign hold = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ARB;
      ptr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      grant_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wr_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ARB: if (go) begin
          state_q <= ISSUE;
          ptr_q <= ptr_d;
          data_q <= req_data[{sel, 3'b000} +: 8];
          wr_q <= 1'b1;
          grant_q <= N_REQ'(1) << sel;
        end
        ISSUE: begin
          state_q <= WAIT_BUSY;
          cnt_q <= '0;
        end
        WAIT_BUSY: if (tx_busy) state_q <= WAIT_DONE;
        else if (tmo) begin
          state_q <= ARB;
          err_q <= 1'b1;
          grant_q <= '0;
        end else cnt_q <= cnt_q + 8'd1;
        default: if (!tx_busy) begin
          state_q <= ARB;
          grant_q <= hold ? grant_q : '0;
        end
      endcase
    end
  assign tx_data = data_q;
  assign tx_wr = wr_q;
  assign grant = grant_q;
  assign err_timeout = err_q;
endmodule
